seg7_scan_ctrl: RTL and testbench

Display controller for the board's eight-digit multiplexed 7-segment display. It accepts two unsigned result values (for example the CPU's two answer words) on a load strobe. It converts them to BCD with an iterative double-dabble sequencer, so no dividers are needed. It then time-multiplexes the eight digits with a fixed dwell per digit. It replaces per-digit `/` and `%` arithmetic in the board top and gives the display path a defined load/busy handshake.

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_scan_ctrl_if.sv | 23 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and the double-dabble step
// for the eight-digit 7-segment scan controller.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int MAX_VAL    = 9999;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0    = 7'b100_0000;
  localparam logic [6:0] SEG_1    = 7'b111_1001;
  localparam logic [6:0] SEG_2    = 7'b010_0100;
  localparam logic [6:0] SEG_3    = 7'b011_0000;
  localparam logic [6:0] SEG_4    = 7'b001_1001;
  localparam logic [6:0] SEG_5    = 7'b001_0010;
  localparam logic [6:0] SEG_6    = 7'b000_0010;
  localparam logic [6:0] SEG_7    = 7'b111_1000;
  localparam logic [6:0] SEG_8    = 7'b000_0000;
  localparam logic [6:0] SEG_9    = 7'b001_0000;
  localparam logic [6:0] SEG_DASH = 7'b011_1111;
  localparam logic [6:0] SEG_OFF  = 7'b111_1111;

  // One double-dabble iteration: +3 on nibbles >= 5,
  // then shift left bringing in the next binary bit.
  function automatic bcd_word_t dd_step(
    input bcd_word_t b,
    input logic      in_bit
  );
    bcd_word_t a;
    for (int i = 0; i < 4; i++) begin
      a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ?
                    b[4*i +: 4] + 4'd3 :
                    b[4*i +: 4];
    end
    return {a[14:0], in_bit};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load/busy handshake plus display pins of the scan controller.
// master: load, val0, val1 out; busy, seg, dp, an in. slave: reverse.
interface seg7_scan_ctrl_if #(
  parameter int VAL_W = 14
) ();
  logic             load;
  logic [VAL_W-1:0] val0;
  logic [VAL_W-1:0] val1;
  logic             busy;
  logic [6:0]       seg;
  logic             dp;
  logic [7:0]       an;

  modport master (
    output load, val0, val1,
    input  busy, seg, dp, an
  );

  modport slave (
    input  load, val0, val1,
    output busy, seg, dp, an
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low segment pattern; overflow shows a dash.
// Ports: dig (BCD digit), ovf (overflow flag) in; seg pattern out.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_digit_t dig,
  input  logic       ovf,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (ovf) begin
      seg = SEG_DASH;
    end else begin
      case (dig)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-value double-dabble converter and 8-digit display scanner.
// Ports: clk, rst (async, active-high); bus (slave): load/val0/val1 in,
// busy/seg/dp/an out. val0 drives digits 7..4, val1 digits 3..0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL = 3000,
  parameter int VAL_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(VAL_W + 1);
  localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    it_q, it_d;
  logic [VAL_W-1:0] bin0_q, bin0_d;
  logic [VAL_W-1:0] bin1_q, bin1_d;
  bcd_word_t        acc0_q, acc0_d;
  bcd_word_t        acc1_q, acc1_d;
  logic             ovfp0_q, ovfp0_d;
  logic             ovfp1_q, ovfp1_d;
  bcd_word_t        dig0_q, dig0_d;
  bcd_word_t        dig1_q, dig1_d;
  logic             ovf0_q, ovf0_d;
  logic             ovf1_q, ovf1_d;

  logic [DW-1:0]    dwell_q, dwell_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  bcd_word_t        step0, step1;
  bcd_word_t        cur_word;
  bcd_digit_t       cur_dig;
  logic             cur_ovf;

  always_comb begin
    step0   = dd_step(acc0_q, bin0_q[VAL_W-1]);
    step1   = dd_step(acc1_q, bin1_q[VAL_W-1]);
    state_d = state_q;
    busy_d  = busy_q;
    it_d    = it_q;
    bin0_d  = bin0_q;
    bin1_d  = bin1_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    ovfp0_d = ovfp0_q;
    ovfp1_d = ovfp1_q;
    dig0_d  = dig0_q;
    dig1_d  = dig1_q;
    ovf0_d  = ovf0_q;
    ovf1_d  = ovf1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          bin0_d  = bus.val0;
          bin1_d  = bus.val1;
          acc0_d  = '0;
          acc1_d  = '0;
          it_d    = '0;
          ovfp0_d = 32'(bus.val0) > 32'(MAX_VAL);
          ovfp1_d = 32'(bus.val1) > 32'(MAX_VAL);
          state_d = ST_CONV;
          busy_d  = 1'b1;
        end
      end
      ST_CONV: begin
        acc0_d = step0;
        acc1_d = step1;
        bin0_d = bin0_q << 1;
        bin1_d = bin1_q << 1;
        it_d   = it_q + 1'b1;
        // Last iteration commits its own result directly.
        if (it_q == CW'(VAL_W - 1)) begin
          dig0_d  = step0;
          dig1_d  = step1;
          ovf0_d  = ovfp0_q;
          ovf1_d  = ovfp1_q;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_word = idx_q[2] ? dig1_q : dig0_q;
    cur_ovf  = idx_q[2] ? ovf1_q : ovf0_q;
    case (idx_q[1:0])
      2'd0:    cur_dig = cur_word[15:12];
      2'd1:    cur_dig = cur_word[11:8];
      2'd2:    cur_dig = cur_word[7:4];
      default: cur_dig = cur_word[3:0];
    endcase
  end

  seg7_decode u_dec (
    .dig (cur_dig),
    .ovf (cur_ovf),
    .seg (seg_d)
  );

  always_comb begin
    if (dwell_q == DW'(DWELL - 1)) begin
      dwell_d = '0;
      idx_d   = idx_q + 1'b1;
    end else begin
      dwell_d = dwell_q + 1'b1;
      idx_d   = idx_q;
    end
    an_d = ~(8'h80 >> idx_q);
    // Decimal point after each value's ones digit.
    dp_d = ~&idx_q[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      it_q    <= '0;
      bin0_q  <= '0;
      bin1_q  <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      ovfp0_q <= 1'b0;
      ovfp1_q <= 1'b0;
      dig0_q  <= '0;
      dig1_q  <= '0;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      dwell_q <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      it_q    <= it_d;
      bin0_q  <= bin0_d;
      bin1_q  <= bin1_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      ovfp0_q <= ovfp0_d;
      ovfp1_q <= ovfp1_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: random and directed loads
// against a decimal-arithmetic model of the display.
module tb_seg7_scan_ctrl;

  localparam int DWELL = 4;
  localparam int VAL_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_scan_ctrl_if #(.VAL_W(VAL_W)) bus ();

  seg7_scan_ctrl #(
    .DWELL (DWELL),
    .VAL_W (VAL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v0;
    int v1;
  } pair_t;

  pair_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    n        = 0;
  int    left     = 0;
  int    shown0   = 0;
  int    shown1   = 0;
  int    busy_cnt = 0;
  logic  busy_prev = 1'b0;

  logic [6:0] pat [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int k);
    int v;
    int div;
    v = (k < 4) ? shown0 : shown1;
    if (v > 9999) return 7'h3F;
    case (k % 4)
      0:       div = 1000;
      1:       div = 100;
      2:       div = 10;
      default: div = 1;
    endcase
    return pat[(v / div) % 10];
  endfunction

  task automatic model_reset();
    n         = 0;
    left      = 0;
    shown0    = 0;
    shown1    = 0;
    busy_cnt  = 0;
    busy_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic reset_check();
    chk("rst_an", bus.an, 32'hFF);
    chk("rst_seg", bus.seg, 32'h7F);
    chk("rst_dp", bus.dp, 1);
    chk("rst_busy", bus.busy, 0);
    model_reset();
  endtask

  // One call per clock edge, #1 after it.
  task automatic step();
    int         k;
    logic [7:0] e_an;
    logic       e_dp;
    pair_t      p;
    n++;
    k    = ((n - 1) / DWELL) % 8;
    e_an = ~(8'h80 >> k);
    e_dp = (k % 4 == 3) ? 1'b0 : 1'b1;
    chk("an", bus.an, e_an);
    chk("dp", bus.dp, e_dp);
    chk("seg", bus.seg, exp_seg(k));
    // Stimulus side: accepted loads are queued.
    if (left == 0 && bus.load === 1'b1) begin
      p.v0 = int'(bus.val0);
      p.v1 = int'(bus.val1);
      exp_q.push_back(p);
      left = VAL_W;
    end else if (left > 0) begin
      left--;
    end
    chk("busy", bus.busy, left > 0);
    if (bus.busy === 1'b1) busy_cnt++;
    // Monitor side: a busy fall presents a committed result.
    if (busy_prev === 1'b1 && bus.busy === 1'b0) begin
      chk("busy_len", busy_cnt, VAL_W);
      busy_cnt = 0;
      chk("pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        p      = exp_q.pop_front();
        shown0 = p.v0;
        shown1 = p.v1;
      end
    end
    busy_prev = bus.busy;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) step();
    end
  end

  task automatic do_load(input int a, input int b);
    bus.load = 1'b1;
    bus.val0 = VAL_W'(a);
    bus.val1 = VAL_W'(b);
    @(negedge clk);
    bus.load = 1'b0;
    bus.val0 = VAL_W'($urandom_range(0, 16383));
    bus.val1 = VAL_W'($urandom_range(0, 16383));
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1 reset_check();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0;
    bus.val0 = '0;
    bus.val1 = '0;
    #2 rst = 1'b1;
    #1 reset_check();
    @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);

    @(posedge clk);
    async_reset();

    do_load(1234, 567);
    repeat (60) @(negedge clk);

    do_load(10000, 9999);
    repeat (50) @(negedge clk);

    do_load(1111, 2222);
    repeat (4) @(negedge clk);
    do_load(3333, 4444);
    repeat (50) @(negedge clk);

    bus.load = 1'b1;
    repeat (40) begin
      bus.val0 = VAL_W'($urandom_range(0, 16383));
      bus.val1 = VAL_W'($urandom_range(0, 16383));
      @(negedge clk);
    end
    bus.load = 1'b0;
    repeat (20) @(negedge clk);

    do_load(9876, 5432);
    repeat (7) @(posedge clk);
    async_reset();
    repeat (40) @(negedge clk);

    repeat (30) begin
      do_load($urandom_range(0, 16383), $urandom_range(0, 16383));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
